exc_sequencer: RTL and testbench
================================

# exc_sequencer

Exception/interrupt sequencer for the LEGv8 pipelined core. Consumes the decoder's NotAnInstr/EStatus/ERet outputs and an optional external interrupt request, then sequences the response. It drains the pipeline, latches the return address (ELR) and syndrome (ESR), redirects fetch to the exception vector, and on ERET redirects fetch back to ELR. It sits between the ID-stage decoder and the PC-select/flush logic. ESR and ELR are the values returned by MRS.

## Interface
- FLUSH_CYCLES, 3, cycles flush is held before vectoring (≥1)
- VECTOR_ADDR, 64'h0000_0000_0000_00D8, exception handler entry PC
- IRQ_CODE, 4'b0001, ESR value for external interrupt
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- instr_valid  in  1  ID-stage instruction is real (not bubble); qualifies all decoder inputs
- NotAnInstr  in  1  decoder: undefined opcode
- EStatus_in  in  4  decoder syndrome (4'b0010 for undefined opcode)
- ERet  in  1  decoder: ERET in ID
- pc_id  in  64  PC of ID-stage instruction
- pc_next  in  64  PC of next instruction to complete (interrupt return address)
- irq_req  in  1  level external interrupt request
- irq_ack  out  1  one-cycle accept pulse
- flush  out  1  squash IF/ID/EX
- Exc  out  1  one-cycle: PC mux selects exc_pc
- exc_pc  out  64  VECTOR_ADDR when Exc, else ELR
- ERetTaken  out  1  one-cycle: PC mux selects exc_pc (=ELR)
- ELR  out  64  exception link register
- ESR  out  4  exception syndrome register
- in_handler  out  1  state HANDLER
- halted  out  1  double fault, sticky until reset

## Operation
- States: IDLE, FLUSH, VECTOR, HANDLER, RETURN, HALT.
- IDLE:
  - instr_valid&NotAnInstr → FLUSH; ELR<=pc_id, ESR<=EStatus_in.
  - Else irq_req (when IRQ feature built) → FLUSH; ELR<=pc_next, ESR<=IRQ_CODE; irq_ack=1 in the following cycle only.
  - NotAnInstr has priority over irq_req in the same cycle. irq stays pending and is not acked.
- FLUSH: flush=1; down-counter loaded with FLUSH_CYCLES-1 on entry; → VECTOR when counter==0. Counter width $clog2(FLUSH_CYCLES+1).
- VECTOR: Exc=1, flush=1, exc_pc=VECTOR_ADDR; → HANDLER.
- HANDLER: in_handler=1; irq_req masked (not acked).
  - instr_valid&ERet → RETURN.
  - instr_valid&NotAnInstr → HALT, ESR<=4'b1111, ELR unchanged.
  - ERet and NotAnInstr both set: NotAnInstr wins.
- RETURN: ERetTaken=1, flush=1, exc_pc=ELR; → IDLE. ELR/ESR retain values.
- HALT: flush=1, halted=1 permanently; only reset exits.
- ERet in IDLE: ignored, no ERetTaken.
- EStatus_in is captured as-is, with no remapping.

## Timing
- Reset (async assert, sync-free release): state IDLE; ELR=0, ESR=0; every 1-bit output 0; exc_pc=0.
- Fault seen at rising edge t → flush cycles t+1..t+FLUSH_CYCLES, Exc at t+FLUSH_CYCLES+1, handler's first fetch at t+FLUSH_CYCLES+2.
- ELR/ESR update at edge t and are visible from cycle t+1.
- irq_ack is high exactly in cycle t+1. Requester must drop irq_req within FLUSH_CYCLES+1 cycles, otherwise it re-triggers after RETURN.
- ERET seen at edge t → ERetTaken/flush in cycle t+1, IDLE at t+2.
- All outputs except exc_pc are registered-state decodes (Moore). exc_pc is a mux on state.
- Reset mid-sequence aborts immediately. No pending ack or vector is emitted after release.

## Configuration
- EXC_IRQ_EN defined: irq_req/IRQ_CODE path active as above.
- EXC_IRQ_EN undefined: irq_req ignored, irq_ack tied 0, IRQ logic not synthesized. Ports remain present.

## Test plan
- Reset low mid-FLUSH → all outputs 0, ELR=0, ESR=0 immediately; after release, IDLE with no Exc.
- Undefined opcode, pc_id=64'h40, EStatus_in=4'b0010, FLUSH_CYCLES=3 → flush 3 cycles, Exc+exc_pc=64'hD8 next, ELR=64'h40, ESR=4'b0010, in_handler=1.
- ERET in HANDLER → ERetTaken=1, exc_pc=64'h40 one cycle, then IDLE. ERET in IDLE → no response.
- irq_req with pc_next=64'h100 (EXC_IRQ_EN) → irq_ack pulse one cycle, ESR=4'b0001, ELR=64'h100. Without macro → no reaction.
- NotAnInstr and irq_req same cycle → ESR=4'b0010, no irq_ack. irq is taken after ERET return.
- NotAnInstr in HANDLER → HALT, ESR=4'b1111, halted/flush held until reset.

Source files
------------

// File: rtl/exc_sequencer.sv
// exc_sequencer: LEGv8 exception/interrupt sequencer (drain, vector, handler, ERET return); EXC_IRQ_EN enables the external interrupt path
module exc_sequencer #(
    parameter int          FLUSH_CYCLES = 3,
    parameter logic [63:0] VECTOR_ADDR  = 64'h0000_0000_0000_00D8,
    parameter logic [3:0]  IRQ_CODE     = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic        NotAnInstr,
    input  logic [3:0]  EStatus_in,
    input  logic        ERet,
    input  logic [63:0] pc_id,
    input  logic [63:0] pc_next,
    input  logic        irq_req,
    output logic        irq_ack,
    output logic        flush,
    output logic        Exc,
    output logic [63:0] exc_pc,
    output logic        ERetTaken,
    output logic [63:0] ELR,
    output logic [3:0]  ESR,
    output logic        in_handler,
    output logic        halted
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, FLUSH, VECTOR, HANDLER, RETURN, HALT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
`ifdef EXC_IRQ_EN
    logic          irq_ack_q;
`else
    logic          unused_irq;
    assign unused_irq = irq_req ^ (^pc_next) ^ (^IRQ_CODE);
`endif

    // sequencer FSM plus ELR/ESR capture; a decoder fault outranks an interrupt in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            ELR   <= '0;
            ESR   <= '0;
`ifdef EXC_IRQ_EN
            irq_ack_q <= 1'b0;
`endif
        end else begin
`ifdef EXC_IRQ_EN
            irq_ack_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (instr_valid && NotAnInstr) begin
                        state <= FLUSH;
                        cnt   <= CW'(FLUSH_CYCLES - 1);
                        ELR   <= pc_id;
                        ESR   <= EStatus_in;
                    end
`ifdef EXC_IRQ_EN
                    else if (irq_req) begin
                        state     <= FLUSH;
                        cnt       <= CW'(FLUSH_CYCLES - 1);
                        ELR       <= pc_next;
                        ESR       <= IRQ_CODE;
                        irq_ack_q <= 1'b1;
                    end
`endif
                end
                FLUSH: begin
                    if (cnt == '0) state <= VECTOR;
                    else cnt <= cnt - 1'b1;
                end
                VECTOR:  state <= HANDLER;
                HANDLER: begin
                    if (instr_valid && NotAnInstr) begin
                        state <= HALT;
                        ESR   <= 4'b1111;
                    end else if (instr_valid && ERet) begin
                        state <= RETURN;
                    end
                end
                RETURN:  state <= IDLE;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXC_IRQ_EN
    assign irq_ack = irq_ack_q;
`else
    assign irq_ack = 1'b0;
`endif

    assign flush      = (state == FLUSH) || (state == VECTOR) || (state == RETURN) || (state == HALT);
    assign Exc        = (state == VECTOR);
    assign ERetTaken  = (state == RETURN);
    assign in_handler = (state == HANDLER);
    assign halted     = (state == HALT);
    assign exc_pc     = (state == VECTOR) ? VECTOR_ADDR : ELR;

endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: directed self-checking bench for exc_sequencer
module tb_exc_sequencer;
    logic        clk, rst_n;
    logic        instr_valid, NotAnInstr, ERet, irq_req;
    logic [3:0]  EStatus_in;
    logic [63:0] pc_id, pc_next;
    logic        irq_ack, flush, Exc, ERetTaken, in_handler, halted;
    logic [63:0] exc_pc, ELR;
    logic [3:0]  ESR;
    int total = 0;
    int bad = 0;

    exc_sequencer dut (
        .clk(clk), .reset(rst_n), .instr_valid(instr_valid), .NotAnInstr(NotAnInstr),
        .EStatus_in(EStatus_in), .ERet(ERet), .pc_id(pc_id), .pc_next(pc_next),
        .irq_req(irq_req), .irq_ack(irq_ack), .flush(flush), .Exc(Exc), .exc_pc(exc_pc),
        .ERetTaken(ERetTaken), .ELR(ELR), .ESR(ESR), .in_handler(in_handler), .halted(halted)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_instr();
        instr_valid = 0;
        NotAnInstr  = 0;
        ERet        = 0;
        EStatus_in  = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_instr();
        irq_req = 0;
        pc_id = 0;
        pc_next = 0;
        #22;
        total++; if ({flush, Exc, ERetTaken, in_handler, halted, irq_ack} !== 6'b0) begin bad++; $display("FAIL reset_bits got=%b exp=000000", {flush, Exc, ERetTaken, in_handler, halted, irq_ack}); end
        total++; if (ELR !== 64'h0 || ESR !== 4'h0) begin bad++; $display("FAIL reset_regs ELR=%h ESR=%h exp 0/0", ELR, ESR); end
        total++; if (exc_pc !== 64'h0) begin bad++; $display("FAIL reset_exc_pc got=%h exp=0", exc_pc); end
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_undef();
        instr_valid = 1; NotAnInstr = 1; EStatus_in = 4'b0010; pc_id = 64'h40;
        step();
        clear_instr();
        total++; if (flush !== 1'b1 || Exc !== 1'b0) begin bad++; $display("FAIL undef_f1 flush=%b Exc=%b exp 1/0", flush, Exc); end
        total++; if (ELR !== 64'h40 || ESR !== 4'b0010) begin bad++; $display("FAIL undef_latch ELR=%h ESR=%h exp 40/2", ELR, ESR); end
        step();
        total++; if (flush !== 1'b1 || Exc !== 1'b0) begin bad++; $display("FAIL undef_f2 flush=%b Exc=%b exp 1/0", flush, Exc); end
        step();
        total++; if (flush !== 1'b1 || Exc !== 1'b0) begin bad++; $display("FAIL undef_f3 flush=%b Exc=%b exp 1/0", flush, Exc); end
        step();
        total++; if (Exc !== 1'b1 || flush !== 1'b1 || exc_pc !== 64'hD8) begin bad++; $display("FAIL undef_vec Exc=%b flush=%b exc_pc=%h exp 1/1/d8", Exc, flush, exc_pc); end
        step();
        total++; if (in_handler !== 1'b1 || flush !== 1'b0 || Exc !== 1'b0) begin bad++; $display("FAIL undef_hdl in_handler=%b flush=%b Exc=%b exp 1/0/0", in_handler, flush, Exc); end
    endtask

    task automatic test_eret();
        instr_valid = 1; ERet = 1;
        step();
        clear_instr();
        total++; if (ERetTaken !== 1'b1 || flush !== 1'b1 || exc_pc !== 64'h40 || in_handler !== 1'b0) begin bad++; $display("FAIL eret_ret ERetTaken=%b flush=%b exc_pc=%h in_handler=%b exp 1/1/40/0", ERetTaken, flush, exc_pc, in_handler); end
        step();
        total++; if (ERetTaken !== 1'b0 || flush !== 1'b0 || in_handler !== 1'b0) begin bad++; $display("FAIL eret_idle ERetTaken=%b flush=%b in_handler=%b exp 0/0/0", ERetTaken, flush, in_handler); end
        total++; if (ELR !== 64'h40 || ESR !== 4'b0010) begin bad++; $display("FAIL eret_keep ELR=%h ESR=%h exp 40/2", ELR, ESR); end
    endtask

    task automatic test_eret_in_idle();
        instr_valid = 1; ERet = 1;
        step();
        clear_instr();
        total++; if (ERetTaken !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL idle_eret1 ERetTaken=%b flush=%b exp 0/0", ERetTaken, flush); end
        step();
        total++; if (ERetTaken !== 1'b0 || flush !== 1'b0 || in_handler !== 1'b0) begin bad++; $display("FAIL idle_eret2 ERetTaken=%b flush=%b in_handler=%b exp 0/0/0", ERetTaken, flush, in_handler); end
    endtask

    task automatic test_irq();
        pc_next = 64'h100; irq_req = 1;
        step();
`ifdef EXC_IRQ_EN
        irq_req = 0;
        total++; if (irq_ack !== 1'b1 || flush !== 1'b1) begin bad++; $display("FAIL irq_ack1 irq_ack=%b flush=%b exp 1/1", irq_ack, flush); end
        total++; if (ELR !== 64'h100 || ESR !== 4'b0001) begin bad++; $display("FAIL irq_latch ELR=%h ESR=%h exp 100/1", ELR, ESR); end
        step();
        total++; if (irq_ack !== 1'b0) begin bad++; $display("FAIL irq_ack2 irq_ack=%b exp 0", irq_ack); end
        step(); step();
        total++; if (Exc !== 1'b1) begin bad++; $display("FAIL irq_vec Exc=%b exp 1", Exc); end
        step();
        instr_valid = 1; ERet = 1;
        step();
        clear_instr();
        total++; if (ERetTaken !== 1'b1 || exc_pc !== 64'h100) begin bad++; $display("FAIL irq_ret ERetTaken=%b exc_pc=%h exp 1/100", ERetTaken, exc_pc); end
        step();
`else
        total++; if (irq_ack !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL irq_off irq_ack=%b flush=%b exp 0/0", irq_ack, flush); end
        total++; if (ELR !== 64'h40 || ESR !== 4'b0010) begin bad++; $display("FAIL irq_off_regs ELR=%h ESR=%h exp 40/2", ELR, ESR); end
        step();
        irq_req = 0;
        total++; if (flush !== 1'b0 || irq_ack !== 1'b0) begin bad++; $display("FAIL irq_off2 irq_ack=%b flush=%b exp 0/0", irq_ack, flush); end
`endif
    endtask

    task automatic test_priority();
        instr_valid = 1; NotAnInstr = 1; EStatus_in = 4'b0010; pc_id = 64'h200;
        pc_next = 64'h300; irq_req = 1;
        step();
        clear_instr();
        total++; if (ESR !== 4'b0010 || ELR !== 64'h200 || irq_ack !== 1'b0 || flush !== 1'b1) begin bad++; $display("FAIL prio_first ESR=%h ELR=%h irq_ack=%b flush=%b exp 2/200/0/1", ESR, ELR, irq_ack, flush); end
        step(); step(); step(); step();
        total++; if (in_handler !== 1'b1 || irq_ack !== 1'b0) begin bad++; $display("FAIL prio_mask in_handler=%b irq_ack=%b exp 1/0", in_handler, irq_ack); end
        instr_valid = 1; ERet = 1;
        step();
        clear_instr();
        total++; if (ERetTaken !== 1'b1 || exc_pc !== 64'h200) begin bad++; $display("FAIL prio_ret ERetTaken=%b exc_pc=%h exp 1/200", ERetTaken, exc_pc); end
        step();
        step();
`ifdef EXC_IRQ_EN
        irq_req = 0;
        total++; if (irq_ack !== 1'b1 || ESR !== 4'b0001 || ELR !== 64'h300 || flush !== 1'b1) begin bad++; $display("FAIL prio_irq irq_ack=%b ESR=%h ELR=%h flush=%b exp 1/1/300/1", irq_ack, ESR, ELR, flush); end
        step(); step(); step(); step();
        instr_valid = 1; ERet = 1;
        step();
        clear_instr();
        step();
`else
        irq_req = 0;
        total++; if (flush !== 1'b0 || ESR !== 4'b0010 || irq_ack !== 1'b0) begin bad++; $display("FAIL prio_noirq flush=%b ESR=%h irq_ack=%b exp 0/2/0", flush, ESR, irq_ack); end
`endif
    endtask

    task automatic test_double_fault();
        instr_valid = 1; NotAnInstr = 1; EStatus_in = 4'b0010; pc_id = 64'h500;
        step();
        clear_instr();
        step(); step(); step(); step();
        total++; if (in_handler !== 1'b1) begin bad++; $display("FAIL df_hdl in_handler=%b exp 1", in_handler); end
        instr_valid = 1; NotAnInstr = 1; ERet = 1; EStatus_in = 4'b0011; pc_id = 64'h600;
        step();
        clear_instr();
        total++; if (halted !== 1'b1 || flush !== 1'b1 || ERetTaken !== 1'b0 || in_handler !== 1'b0) begin bad++; $display("FAIL df_halt halted=%b flush=%b ERetTaken=%b in_handler=%b exp 1/1/0/0", halted, flush, ERetTaken, in_handler); end
        total++; if (ESR !== 4'b1111 || ELR !== 64'h500) begin bad++; $display("FAIL df_regs ESR=%h ELR=%h exp f/500", ESR, ELR); end
        instr_valid = 1; ERet = 1;
        step(); step();
        clear_instr();
        step();
        total++; if (halted !== 1'b1 || flush !== 1'b1 || ERetTaken !== 1'b0) begin bad++; $display("FAIL df_sticky halted=%b flush=%b ERetTaken=%b exp 1/1/0", halted, flush, ERetTaken); end
    endtask

    task automatic test_reset_midflush();
        rst_n = 0;
        #1;
        total++; if (halted !== 1'b0 || flush !== 1'b0 || ESR !== 4'h0 || ELR !== 64'h0) begin bad++; $display("FAIL rst_halt halted=%b flush=%b ESR=%h ELR=%h exp 0/0/0/0", halted, flush, ESR, ELR); end
        @(negedge clk);
        rst_n = 1;
        step();
        instr_valid = 1; NotAnInstr = 1; EStatus_in = 4'b0010; pc_id = 64'h40;
        step();
        clear_instr();
        step();
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL rmf_pre flush=%b exp 1", flush); end
        rst_n = 0;
        #1;
        total++; if ({flush, Exc, ERetTaken, in_handler, halted, irq_ack} !== 6'b0 || ELR !== 64'h0 || ESR !== 4'h0 || exc_pc !== 64'h0) begin bad++; $display("FAIL rmf_abort bits=%b ELR=%h ESR=%h exc_pc=%h exp 0", {flush, Exc, ERetTaken, in_handler, halted, irq_ack}, ELR, ESR, exc_pc); end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (Exc !== 1'b0 || flush !== 1'b0 || in_handler !== 1'b0) begin bad++; $display("FAIL rmf_after%0d Exc=%b flush=%b in_handler=%b exp 0/0/0", i, Exc, flush, in_handler); end
        end
    endtask

    initial begin
        test_reset();
        test_undef();
        test_eret();
        test_eret_in_idle();
        test_irq();
        test_priority();
        test_double_fault();
        test_reset_midflush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
